// File: rtl/except_handler_pkg.sv
// Shared types, cause codes, CSR addresses and FSM encodings for the exception handler.
// Everything that both the handler and its CSR storage need to agree on lives here.
package except_handler_pkg;

    typedef struct packed {
        logic        except;
        logic [63:0] epc;
        logic [63:0] ecause;
        logic [63:0] etval;
    } except_pack_t;

    localparam logic [63:0] CAUSE_ILLEGAL_INST = 64'd2;
    localparam logic [63:0] CAUSE_BREAKPOINT   = 64'd3;
    localparam logic [63:0] CAUSE_U_CALL       = 64'd8;
    localparam logic [63:0] CAUSE_S_CALL       = 64'd9;
    localparam logic [63:0] CAUSE_H_CALL       = 64'd10;
    localparam logic [63:0] CAUSE_M_CALL       = 64'd11;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEDELEG = 12'h302;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    // mstatus field positions
    localparam int MS_SIE  = 1;
    localparam int MS_MIE  = 3;
    localparam int MS_SPIE = 5;
    localparam int MS_MPIE = 7;
    localparam int MS_SPP  = 8;
    localparam int MS_MPP  = 11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EV_TRAP = 2'd0,
        EV_MRET = 2'd1,
        EV_SRET = 2'd2
    } event_t;

    typedef enum logic [2:0] {
        UPD_NONE  = 3'd0,
        UPD_MTRAP = 3'd1,
        UPD_STRAP = 3'd2,
        UPD_MRET  = 3'd3,
        UPD_SRET  = 3'd4
    } upd_t;

    // Only direct mode is supported, so the mode bits never reach the target PC.
    function automatic logic [63:0] tvec_base(input logic [63:0] tvec);
        return tvec & ~64'h3;
    endfunction

endpackage

// File: rtl/except_handler_csr_file.sv
// Machine/supervisor trap CSR storage with combinational read mux.
// Trap/xRET updates and software writes are mutually exclusive by construction in the parent.
module except_handler_csr_file
    import except_handler_pkg::*;
#(
    parameter logic [63:0] MTVEC_RESET = 64'h0,
    parameter logic [63:0] STVEC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_we,
    input  logic [11:0] sw_addr,
    input  logic [63:0] sw_wdata,
    input  upd_t        upd,
    input  logic [63:0] upd_epc,
    input  logic [63:0] upd_cause,
    input  logic [63:0] upd_tval,
    input  logic [1:0]  cur_priv,
    input  logic [11:0] raddr,
    output logic [63:0] rdata,
    output logic [63:0] mtvec,
    output logic [63:0] stvec,
    output logic [63:0] mepc,
    output logic [63:0] sepc,
    output logic [63:0] medeleg,
    output logic [1:0]  mpp,
    output logic        spp
);

    logic        mie, mpie, sie, spie;
    logic [63:0] mcause, mtval, scause, stval;
    logic [63:0] mstatus;

    always_comb begin
        mstatus                    = '0;
        mstatus[MS_SIE]            = sie;
        mstatus[MS_MIE]            = mie;
        mstatus[MS_SPIE]           = spie;
        mstatus[MS_MPIE]           = mpie;
        mstatus[MS_SPP]            = spp;
        mstatus[MS_MPP+1:MS_MPP]   = mpp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie     <= 1'b0;
            mpie    <= 1'b0;
            mpp     <= 2'b00;
            sie     <= 1'b0;
            spie    <= 1'b0;
            spp     <= 1'b0;
            mtvec   <= MTVEC_RESET;
            stvec   <= STVEC_RESET;
            mepc    <= '0;
            mcause  <= '0;
            mtval   <= '0;
            medeleg <= '0;
            sepc    <= '0;
            scause  <= '0;
            stval   <= '0;
        end else begin
            case (upd)
                UPD_MTRAP: begin
                    mepc   <= upd_epc;
                    mcause <= upd_cause;
                    mtval  <= upd_tval;
                    mpie   <= mie;
                    mie    <= 1'b0;
                    mpp    <= cur_priv;
                end
                UPD_STRAP: begin
                    sepc   <= upd_epc;
                    scause <= upd_cause;
                    stval  <= upd_tval;
                    spie   <= sie;
                    sie    <= 1'b0;
                    spp    <= cur_priv[0];
                end
                UPD_MRET: begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                    mpp  <= PRIV_U;
                end
                UPD_SRET: begin
                    sie  <= spie;
                    spie <= 1'b1;
                    spp  <= 1'b0;
                end
                default: begin
                    if (sw_we) begin
                        case (sw_addr)
                            CSR_MSTATUS: begin
                                sie  <= sw_wdata[MS_SIE];
                                mie  <= sw_wdata[MS_MIE];
                                spie <= sw_wdata[MS_SPIE];
                                mpie <= sw_wdata[MS_MPIE];
                                spp  <= sw_wdata[MS_SPP];
                                mpp  <= sw_wdata[MS_MPP+1:MS_MPP];
                            end
                            CSR_MEDELEG: medeleg <= sw_wdata;
                            CSR_MTVEC:   mtvec   <= sw_wdata;
                            CSR_MEPC:    mepc    <= sw_wdata;
                            CSR_MCAUSE:  mcause  <= sw_wdata;
                            CSR_MTVAL:   mtval   <= sw_wdata;
                            CSR_STVEC:   stvec   <= sw_wdata;
                            CSR_SEPC:    sepc    <= sw_wdata;
                            CSR_SCAUSE:  scause  <= sw_wdata;
                            CSR_STVAL:   stval   <= sw_wdata;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (raddr)
            CSR_MSTATUS: rdata = mstatus;
            CSR_MEDELEG: rdata = medeleg;
            CSR_MTVEC:   rdata = mtvec;
            CSR_MEPC:    rdata = mepc;
            CSR_MCAUSE:  rdata = mcause;
            CSR_MTVAL:   rdata = mtval;
            CSR_STVEC:   rdata = stvec;
            CSR_SEPC:    rdata = sepc;
            CSR_SCAUSE:  rdata = scause;
            CSR_STVAL:   rdata = stval;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: rtl/except_handler.sv
// Trap/xRET sequencer: accepts one commit-stage event, flushes, updates CSRs and privilege,
// then redirects fetch. States: IDLE (accepting), COMMIT (flush), REDIRECT (fetch redirect).
module except_handler
    import except_handler_pkg::*;
#(
    parameter logic [63:0] MTVEC_RESET = 64'h0,
    parameter logic [63:0] STVEC_RESET = 64'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  except_pack_t except_i,
    input  logic         mret_i,
    input  logic         sret_i,
    input  logic         csr_we_i,
    input  logic [11:0]  csr_addr_i,
    input  logic [63:0]  csr_wdata_i,
    input  logic [11:0]  csr_raddr_i,
    output logic [63:0]  csr_rdata_o,
    output logic [1:0]   priv_o,
    output logic         stall_o,
    output logic         flush_o,
    output logic         redirect_o,
    output logic [63:0]  redirect_pc_o
);

    state_t      state;
    event_t      ev;
    logic [63:0] pend_epc, pend_cause, pend_tval;
    logic        accept, sw_we, deleg;
    upd_t        upd;
    logic [63:0] target;
    logic [63:0] mtvec, stvec, mepc, sepc, medeleg;
    logic [1:0]  mpp;
    logic        spp;

    assign accept = (state == ST_IDLE) && (except_i.except || mret_i || sret_i);
    // A software write colliding with an accepted event loses; the event owns the CSRs.
    assign sw_we  = csr_we_i && (state == ST_IDLE) && !accept;
    assign deleg  = (priv_o != PRIV_M) && medeleg[pend_cause[5:0]];

    always_comb begin
        upd    = UPD_NONE;
        target = '0;
        if (state == ST_COMMIT) begin
            case (ev)
                EV_TRAP: begin
                    upd    = deleg ? UPD_STRAP : UPD_MTRAP;
                    target = deleg ? tvec_base(stvec) : tvec_base(mtvec);
                end
                EV_MRET: begin
                    upd    = UPD_MRET;
                    target = mepc;
                end
                EV_SRET: begin
                    upd    = UPD_SRET;
                    target = sepc;
                end
                default: begin
                    upd    = UPD_NONE;
                    target = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            ev            <= EV_TRAP;
            pend_epc      <= '0;
            pend_cause    <= '0;
            pend_tval     <= '0;
            priv_o        <= PRIV_M;
            stall_o       <= 1'b0;
            flush_o       <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_COMMIT;
                        pend_epc   <= except_i.epc;
                        pend_cause <= except_i.ecause;
                        pend_tval  <= except_i.etval;
                        if (except_i.except)  ev <= EV_TRAP;
                        else if (mret_i)      ev <= EV_MRET;
                        else                  ev <= EV_SRET;
                        stall_o    <= 1'b1;
                        flush_o    <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state         <= ST_REDIRECT;
                    flush_o       <= 1'b0;
                    redirect_o    <= 1'b1;
                    redirect_pc_o <= target;
                    case (upd)
                        UPD_MTRAP: priv_o <= PRIV_M;
                        UPD_STRAP: priv_o <= PRIV_S;
                        UPD_MRET:  priv_o <= mpp;
                        UPD_SRET:  priv_o <= {1'b0, spp};
                        default:   priv_o <= priv_o;
                    endcase
                end
                ST_REDIRECT: begin
                    state         <= ST_IDLE;
                    stall_o       <= 1'b0;
                    redirect_o    <= 1'b0;
                    redirect_pc_o <= '0;
                end
                default: begin
                    state         <= ST_IDLE;
                    stall_o       <= 1'b0;
                    flush_o       <= 1'b0;
                    redirect_o    <= 1'b0;
                    redirect_pc_o <= '0;
                end
            endcase
        end
    end

    except_handler_csr_file #(
        .MTVEC_RESET(MTVEC_RESET),
        .STVEC_RESET(STVEC_RESET)
    ) u_csr_file (
        .clk       (clk),
        .rst       (rst),
        .sw_we     (sw_we),
        .sw_addr   (csr_addr_i),
        .sw_wdata  (csr_wdata_i),
        .upd       (upd),
        .upd_epc   (pend_epc),
        .upd_cause (pend_cause),
        .upd_tval  (pend_tval),
        .cur_priv  (priv_o),
        .raddr     (csr_raddr_i),
        .rdata     (csr_rdata_o),
        .mtvec     (mtvec),
        .stvec     (stvec),
        .mepc      (mepc),
        .sepc      (sepc),
        .medeleg   (medeleg),
        .mpp       (mpp),
        .spp       (spp)
    );

endmodule

// File: tb/tb_except_handler.sv
// Directed bench for except_handler: expected redirect targets are queued when an event is
// driven and popped when redirect_o fires; CSR/privilege effects are checked afterwards.
module tb_except_handler;
    import except_handler_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    except_pack_t except_i;
    logic         mret_i, sret_i, csr_we_i;
    logic [11:0]  csr_addr_i, csr_raddr_i;
    logic [63:0]  csr_wdata_i, csr_rdata_o;
    logic [1:0]   priv_o;
    logic         stall_o, flush_o, redirect_o;
    logic [63:0]  redirect_pc_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    except_handler #(
        .MTVEC_RESET(64'h40),
        .STVEC_RESET(64'h80)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .except_i      (except_i),
        .mret_i        (mret_i),
        .sret_i        (sret_i),
        .csr_we_i      (csr_we_i),
        .csr_addr_i    (csr_addr_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_raddr_i   (csr_raddr_i),
        .csr_rdata_o   (csr_rdata_o),
        .priv_o        (priv_o),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        csr_raddr_i = addr;
        #1;
        chk(tag, csr_rdata_o, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [63:0] data);
        @(posedge clk); #1;
        csr_we_i = 1'b1; csr_addr_i = addr; csr_wdata_i = data;
        @(posedge clk); #1;
        csr_we_i = 1'b0;
    endtask

    // Drives one event cycle, checks COMMIT, waits (bounded) for the redirect and scores it.
    task automatic fire(input logic ex, input logic [63:0] epc, input logic [63:0] cause,
                        input logic [63:0] tval, input logic m, input logic s,
                        input logic [63:0] exp_pc, input logic mret_late,
                        input logic we, input logic [11:0] wa, input logic [63:0] wd);
        int lat;
        logic [63:0] e;
        @(posedge clk); #1;
        except_i = '{except: ex, epc: epc, ecause: cause, etval: tval};
        mret_i = m; sret_i = s;
        csr_we_i = we; csr_addr_i = wa; csr_wdata_i = wd;
        exp_q.push_back(exp_pc);
        @(posedge clk); #1;
        except_i = '0; mret_i = mret_late; sret_i = 1'b0; csr_we_i = 1'b0;
        chk("commit_flush", 64'(flush_o), 64'd1);
        chk("commit_stall", 64'(stall_o), 64'd1);
        chk("commit_redirect", 64'(redirect_o), 64'd0);
        lat = 1;
        while (!redirect_o && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        mret_i = 1'b0;
        chk("redirect_latency", 64'(lat), 64'd2);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("redirect_pc", redirect_pc_o, e);
        end
        chk("redirect_stall", 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        chk("idle_stall", 64'(stall_o), 64'd0);
        chk("idle_redirect", 64'(redirect_o), 64'd0);
        chk("idle_pc", redirect_pc_o, 64'd0);
    endtask

    task automatic no_redirect(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (redirect_o) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        except_i = '0; mret_i = 1'b0; sret_i = 1'b0;
        csr_we_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0; csr_raddr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_priv", 64'(priv_o), 64'(PRIV_M));
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_flush", 64'(flush_o), 64'd0);
        chk("rst_redirect", 64'(redirect_o), 64'd0);
        rst = 1'b0;
        chk_csr("rst_mtvec", CSR_MTVEC, 64'h40);
        chk_csr("rst_stvec", CSR_STVEC, 64'h80);
        chk_csr("rst_mstatus", CSR_MSTATUS, 64'h0);

        // ecall from M lands on mtvec
        wr(CSR_MTVEC, 64'h8000_0100);
        fire(1'b1, 64'h1000, CAUSE_M_CALL, 64'h0, 1'b0, 1'b0, 64'h8000_0100, 1'b0, 1'b0, 12'h0, 64'h0);
        chk_csr("m_mepc", CSR_MEPC, 64'h1000);
        chk_csr("m_mcause", CSR_MCAUSE, 64'd11);
        chk_csr("m_mstatus", CSR_MSTATUS, 64'h1800);
        chk("m_priv", 64'(priv_o), 64'(PRIV_M));

        // mret down to U
        wr(CSR_MSTATUS, 64'h0);
        wr(CSR_MEPC, 64'h500);
        fire(1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h500, 1'b0, 1'b0, 12'h0, 64'h0);
        chk("u_priv", 64'(priv_o), 64'(PRIV_U));
        chk_csr("u_mstatus", CSR_MSTATUS, 64'h80);

        // delegated ecall from U goes to S, stvec mode bits stripped
        wr(CSR_MEDELEG, 64'h108);
        wr(CSR_STVEC, 64'h2003);
        fire(1'b1, 64'h400, CAUSE_U_CALL, 64'h0, 1'b0, 1'b0, 64'h2000, 1'b0, 1'b0, 12'h0, 64'h0);
        chk_csr("s_sepc", CSR_SEPC, 64'h400);
        chk_csr("s_scause", CSR_SCAUSE, 64'd8);
        chk_csr("s_mcause_kept", CSR_MCAUSE, 64'd11);
        chk_csr("s_mstatus", CSR_MSTATUS, 64'h80);
        chk("s_priv", 64'(priv_o), 64'(PRIV_S));

        // mret with MPP=U, MPIE=1
        wr(CSR_MEPC, 64'h3000);
        fire(1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h3000, 1'b0, 1'b0, 12'h0, 64'h0);
        chk("mret_priv", 64'(priv_o), 64'(PRIV_U));
        chk_csr("mret_mstatus", CSR_MSTATUS, 64'h88);

        // sret with SPP=1, SPIE=1
        wr(CSR_MSTATUS, 64'h1A8);
        fire(1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h400, 1'b0, 1'b0, 12'h0, 64'h0);
        chk("sret_priv", 64'(priv_o), 64'(PRIV_S));
        chk_csr("sret_mstatus", CSR_MSTATUS, 64'hAA);

        // except + mret together: trap wins; mret held during COMMIT is ignored
        fire(1'b1, 64'h600, CAUSE_ILLEGAL_INST, 64'h11, 1'b1, 1'b0, 64'h8000_0100, 1'b1, 1'b0, 12'h0, 64'h0);
        no_redirect("no_second_redirect", 4);
        chk_csr("pri_mepc", CSR_MEPC, 64'h600);
        chk_csr("pri_mcause", CSR_MCAUSE, 64'd2);
        chk_csr("pri_mtval", CSR_MTVAL, 64'h11);
        chk_csr("pri_mstatus", CSR_MSTATUS, 64'h8A2);
        chk("pri_priv", 64'(priv_o), 64'(PRIV_M));

        // software write to mtvec colliding with a trap is dropped; medeleg ignored in M
        fire(1'b1, 64'h700, CAUSE_BREAKPOINT, 64'h0, 1'b0, 1'b0, 64'h8000_0100, 1'b0, 1'b1, CSR_MTVEC, 64'hDEAD_0000);
        chk_csr("drop_mtvec", CSR_MTVEC, 64'h8000_0100);
        chk_csr("drop_mcause", CSR_MCAUSE, 64'd3);
        chk_csr("drop_mstatus", CSR_MSTATUS, 64'h1822);
        chk_csr("unlisted_read", 12'h100, 64'h0);

        // reset in the middle of COMMIT abandons the trap
        @(posedge clk); #1;
        except_i = '{except: 1'b1, epc: 64'h900, ecause: CAUSE_ILLEGAL_INST, etval: 64'hDEAD_BEEF};
        @(posedge clk); #1;
        except_i = '0;
        chk("rstc_flush_before", 64'(flush_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstc_priv", 64'(priv_o), 64'(PRIV_M));
        chk("rstc_stall", 64'(stall_o), 64'd0);
        chk("rstc_flush", 64'(flush_o), 64'd0);
        chk("rstc_redirect", 64'(redirect_o), 64'd0);
        chk("rstc_pc", redirect_pc_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_csr("rstc_mtval", CSR_MTVAL, 64'h0);
        chk_csr("rstc_mcause", CSR_MCAUSE, 64'h0);
        chk_csr("rstc_mtvec", CSR_MTVEC, 64'h40);
        no_redirect("rstc_no_redirect", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
